// File: rtl/fractal_pkg.sv
// -----------------------------------------------------------------------------
// fractal_pkg
//   Shared definitions for the fractal coordinate scheduler blocks:
//   default coordinate / dimension widths and the scheduler FSM encoding.
// -----------------------------------------------------------------------------
package fractal_pkg;

  // Signed fixed-point coordinate width (Q4.28) and frame dimension width.
  localparam int COORD_W = 32;
  localparam int DIM_W   = 11;

  // Scheduler FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fractal_pixel_counter.sv
// -----------------------------------------------------------------------------
// fractal_pixel_counter
//   Column / row position of the pixel currently offered to the compute core.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     clear_i            restart at pixel (0,0)
//     advance_i          current pixel accepted, move to the next one
//     width_i, height_i  frame dimensions (nonzero while counting)
//     col_o, row_o       current position
//     eol_o              current pixel is the last of its line
//     last_o             current pixel is the last of the frame
// -----------------------------------------------------------------------------
module fractal_pixel_counter
  import fractal_pkg::*;
#(
  parameter int CNT_W = DIM_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] height_i,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             eol_o,
  output logic             last_o
);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_max;
  logic [CNT_W-1:0] row_max;

  assign col_max = width_i - CNT_W'(1);
  assign row_max = height_i - CNT_W'(1);

  assign eol_o  = (col_q == col_max);
  assign last_o = eol_o && (row_q == row_max);
  assign col_o  = col_q;
  assign row_o  = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (last_o) begin
        col_d = '0;
        row_d = '0;
      end else if (eol_o) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/fractal_scheduler.sv
// -----------------------------------------------------------------------------
// fractal_scheduler
//   Walks a width x height pixel grid and streams the complex-plane coordinate
//   of every pixel to a compute core over a valid/ready handshake.
//   Ports:
//     aclk, aresetn            clock, asynchronous active-low reset
//     cfg_width, cfg_height    frame size in pixels / lines
//     cfg_x0, cfg_y0           coordinate of the top-left pixel
//     cfg_dx, cfg_dy           real step per pixel, imaginary step per line
//     cfg_start                level request for a frame
//     cfg_continuous           start the next frame right after this one
//     busy                     frame in progress (LOAD, RUN, DONE)
//     frame_done               one-cycle pulse after the last pixel
//     m_valid/m_ready          coordinate stream handshake
//     m_cr, m_ci               pixel coordinate
//     m_sof, m_eol             first pixel of frame / last pixel of line
// -----------------------------------------------------------------------------
module fractal_scheduler #(
  parameter int COORD_W = fractal_pkg::COORD_W,
  parameter int DIM_W   = fractal_pkg::DIM_W
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_y0,
  input  logic [COORD_W-1:0] cfg_dx,
  input  logic [COORD_W-1:0] cfg_dy,
  input  logic               cfg_start,
  input  logic               cfg_continuous,
  output logic               busy,
  output logic               frame_done,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COORD_W-1:0] m_cr,
  output logic [COORD_W-1:0] m_ci,
  output logic               m_sof,
  output logic               m_eol
);

  import fractal_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [DIM_W-1:0]   width_q, height_q;
  logic [COORD_W-1:0] x0_q, dx_q, dy_q;
  logic [COORD_W-1:0] cr_q, ci_q;

  logic               dims_ok;
  logic               load_en;
  logic               xfer;
  logic [DIM_W-1:0]   col, row;
  logic               eol, last;

  // A zero dimension would describe an empty frame; such requests are ignored.
  assign dims_ok = (cfg_width != '0) && (cfg_height != '0);
  assign load_en = (state_q == ST_LOAD);
  assign m_valid = (state_q == ST_RUN);
  assign xfer    = m_valid && m_ready;

  fractal_pixel_counter #(
    .CNT_W (DIM_W)
  ) u_pixel_counter (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .clear_i   (load_en),
    .advance_i (xfer),
    .width_i   (width_q),
    .height_i  (height_q),
    .col_o     (col),
    .row_o     (row),
    .eol_o     (eol),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_start && dims_ok) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (xfer && last) state_d = ST_DONE;
      ST_DONE: state_d = (cfg_continuous && cfg_start && dims_ok) ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      x0_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      cr_q     <= '0;
      ci_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        // Shadow copies isolate the running frame from cfg changes.
        width_q  <= cfg_width;
        height_q <= cfg_height;
        x0_q     <= cfg_x0;
        dx_q     <= cfg_dx;
        dy_q     <= cfg_dy;
        cr_q     <= cfg_x0;
        ci_q     <= cfg_y0;
      end else if (xfer) begin
        if (eol) begin
          cr_q <= x0_q;
          // Imaginary axis decreases downwards; no update after the last line.
          if (!last) ci_q <= ci_q - dy_q;
        end else begin
          cr_q <= cr_q + dx_q;
        end
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign m_cr       = cr_q;
  assign m_ci       = ci_q;
  // Gated with m_valid so both flags read 0 outside RUN (including reset).
  assign m_sof      = m_valid && (col == '0) && (row == '0);
  assign m_eol      = m_valid && eol;

endmodule

// File: tb/tb_fractal_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fractal_scheduler
//   Directed scenarios with a scoreboard of expected pixels; a monitor pops
//   and compares on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_fractal_scheduler;

  localparam int CW = 32;
  localparam int DW = 11;

  typedef struct {
    logic [CW-1:0] cr;
    logic [CW-1:0] ci;
    logic          sof;
    logic          eol;
  } pix_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] cfg_width = '0;
  logic [DW-1:0] cfg_height = '0;
  logic [CW-1:0] cfg_x0 = '0;
  logic [CW-1:0] cfg_y0 = '0;
  logic [CW-1:0] cfg_dx = '0;
  logic [CW-1:0] cfg_dy = '0;
  logic          cfg_start = 1'b0;
  logic          cfg_continuous = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] m_cr;
  logic [CW-1:0] m_ci;
  logic          m_sof;
  logic          m_eol;

  pix_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   xfer_cnt = 0;
  int   cyc = 0;
  int   last_xfer_cyc = -100;
  int   ready_mode = 0;

  fractal_scheduler dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_x0         (cfg_x0),
    .cfg_y0         (cfg_y0),
    .cfg_dx         (cfg_dx),
    .cfg_dy         (cfg_dy),
    .cfg_start      (cfg_start),
    .cfg_continuous (cfg_continuous),
    .busy           (busy),
    .frame_done     (frame_done),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_cr           (m_cr),
    .m_ci           (m_ci),
    .m_sof          (m_sof),
    .m_eol          (m_eol)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixels computed directly from position (no accumulation).
  task automatic push_frame(input int w, input int h, input logic [CW-1:0] x0,
                            input logic [CW-1:0] y0, input logic [CW-1:0] dx,
                            input logic [CW-1:0] dy);
    pix_t p;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        p.cr  = x0 + CW'(c) * dx;
        p.ci  = y0 - CW'(r) * dy;
        p.sof = (r == 0) && (c == 0);
        p.eol = (c == w - 1);
        sb.push_back(p);
      end
    end
  endtask

  task automatic set_cfg(input int w, input int h, input logic [CW-1:0] x0,
                         input logic [CW-1:0] y0, input logic [CW-1:0] dx,
                         input logic [CW-1:0] dy);
    cfg_width  = DW'(w);
    cfg_height = DW'(h);
    cfg_x0     = x0;
    cfg_y0     = y0;
    cfg_dx     = dx;
    cfg_dy     = dy;
  endtask

  // Raise start; LOAD follows the sampling edge, first valid one cycle later.
  task automatic start_frame(input bit keep);
    @(posedge aclk); #1 cfg_start = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_valid_low", 64'(m_valid), 64'(0));
    @(negedge aclk);
    chk("first_valid_n2", 64'(m_valid), 64'(1));
    if (!keep) cfg_start = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int k;
    k = 0;
    while (xfer_cnt < n && k < 3000) begin
      @(negedge aclk); #1;
      k++;
    end
    if (xfer_cnt < n) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: got %0d transfers expected %0d", xfer_cnt, n);
    end
  endtask

  task automatic wait_done(input int remaining);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!frame_done && n < 3000);
    if (!frame_done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no frame_done expected pulse");
    end else begin
      chk("frame_size", 64'(sb.size()), 64'(remaining));
      @(negedge aclk);
      chk("done_one_cycle", 64'(frame_done), 64'(0));
    end
  endtask

  // m_ready driver: constant 1, or toggling 1010...
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (ready_mode == 1) m_ready = ~m_ready;
      else m_ready = 1'b1;
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    logic          hold;
    logic [CW-1:0] h_cr, h_ci;
    logic          h_sof, h_eol;
    pix_t          e;
    hold = 1'b0;
    h_cr = '0; h_ci = '0; h_sof = 1'b0; h_eol = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (hold && m_valid) begin
        chk("stall_coord", {m_cr, m_ci}, {h_cr, h_ci});
        chk("stall_flags", 64'({m_sof, m_eol}), 64'({h_sof, h_eol}));
      end
      hold  = m_valid && !m_ready;
      h_cr  = m_cr;
      h_ci  = m_ci;
      h_sof = m_sof;
      h_eol = m_eol;
      if (frame_done) chk("done_after_last", 64'(cyc - last_xfer_cyc), 64'(1));
      if (m_valid && m_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        $display("[TB] xfer %0d cr=%08h ci=%08h sof=%0d eol=%0d", xfer_cnt, m_cr, m_ci, m_sof, m_eol);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: got extra pixel cr=%0h expected none", m_cr);
        end else begin
          e = sb.pop_front();
          chk("pix_cr", 64'(m_cr), 64'(e.cr));
          chk("pix_ci", 64'(m_ci), 64'(e.ci));
          chk("pix_sof", 64'(m_sof), 64'(e.sof));
          chk("pix_eol", 64'(m_eol), 64'(e.eol));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int base;
    bit seen;

    // Reset state.
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_sof", 64'(m_sof), 64'(0));
    chk("rst_eol", 64'(m_eol), 64'(0));
    chk("rst_cr", 64'(m_cr), 64'(0));
    chk("rst_ci", 64'(m_ci), 64'(0));
    @(posedge aclk); #1 aresetn = 1'b1;

    // 4x3 frame, full throughput; real and imaginary stepping.
    set_cfg(4, 3, 32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0800_0000);
    push_frame(4, 3, 32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0800_0000);
    start_frame(1'b0);
    wait_done(0);
    chk("idle_after_frame", 64'(busy), 64'(0));

    // Same frame with m_ready toggling; stalls checked by the monitor.
    ready_mode = 1;
    push_frame(4, 3, 32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0800_0000);
    start_frame(1'b0);
    wait_done(0);
    ready_mode = 0;

    // Zero width: request ignored.
    set_cfg(0, 3, 32'h0, 32'h0, 32'h1, 32'h1);
    @(posedge aclk); #1 cfg_start = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge aclk);
      if (busy || m_valid) seen = 1'b1;
    end
    chk("zero_width_ignored", 64'(seen), 64'(0));
    cfg_start = 1'b0;

    // Single-column frame: every pixel ends a line.
    set_cfg(1, 2, 32'h0300_0000, 32'h0200_0000, 32'h1000_0000, 32'h0100_0000);
    push_frame(1, 2, 32'h0300_0000, 32'h0200_0000, 32'h1000_0000, 32'h0100_0000);
    start_frame(1'b0);
    wait_done(0);

    // Continuous mode, dx changed mid-frame; x0 negative to exercise wrap.
    set_cfg(4, 3, 32'hF000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0800_0000);
    push_frame(4, 3, 32'hF000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0800_0000);
    push_frame(4, 3, 32'hF000_0000, 32'h0000_0000, 32'h0400_0000, 32'h0800_0000);
    cfg_continuous = 1'b1;
    base = xfer_cnt;
    start_frame(1'b1);
    wait_xfers(base + 5);
    cfg_dx = 32'h0400_0000;
    wait_done(12);
    // wait_done leaves us in LOAD of the second frame.
    chk("cont_load_valid", 64'(m_valid), 64'(0));
    chk("cont_load_busy", 64'(busy), 64'(1));
    @(negedge aclk);
    chk("cont_run_valid", 64'(m_valid), 64'(1));
    cfg_start = 1'b0;
    cfg_continuous = 1'b0;
    wait_done(0);
    chk("cont_idle", 64'(busy), 64'(0));

    // Reset in the middle of a frame.
    set_cfg(4, 3, 32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0800_0000);
    push_frame(4, 3, 32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0800_0000);
    base = xfer_cnt;
    start_frame(1'b0);
    wait_xfers(base + 5);
    @(posedge aclk); #1 aresetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(m_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cr", 64'(m_cr), 64'(0));
    chk("midrst_ci", 64'(m_ci), 64'(0));
    sb.delete();
    #2 aresetn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      if (m_valid || busy) seen = 1'b1;
    end
    chk("post_rst_quiet", 64'(seen), 64'(0));
    chk("post_rst_xfers", 64'(xfer_cnt), 64'(base + 5));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
